// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin time-shared 1100111 detector for 4 serial channels.
// Define SEQ_DET_SCHED_OVERLAP_EN to let a completed match seed the next one.
module seq_det_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_valid,
    input  logic [3:0]  in_bit,
    output logic [3:0]  in_ready,
    input  logic [3:0]  clr,
    output logic [3:0]  hit,
    output logic [15:0] hit_total
);
    logic [2:0] ctx [4];
    logic [1:0] p, g;
    logic       gv;
    logic [3:0] elig;
    logic [2:0] nk;

    function automatic logic [2:0] next_k(input logic [2:0] k, input logic b);
        case (k)
            3'd0: next_k = b ? 3'd1 : 3'd0;
            3'd1: next_k = b ? 3'd2 : 3'd0;
            3'd2: next_k = b ? 3'd2 : 3'd3;
            3'd3: next_k = b ? 3'd1 : 3'd4;
            3'd4: next_k = b ? 3'd5 : 3'd0;
            3'd5: next_k = b ? 3'd6 : 3'd0;
            3'd6: next_k = b ? 3'd7 : 3'd3;
`ifdef SEQ_DET_SCHED_OVERLAP_EN
            default: next_k = b ? 3'd2 : 3'd3;
`else
            default: next_k = b ? 3'd1 : 3'd0;
`endif
        endcase
    endfunction

    // scan offsets high to low so the closest eligible channel after p wins
    always_comb begin
        elig = rst ? 4'b0000 : in_valid & ~clr;
        g = p;
        gv = 1'b0;
        for (int i = 3; i >= 0; i--)
            if (elig[p + 2'(i)]) begin
                g = p + 2'(i);
                gv = 1'b1;
            end
        in_ready = gv ? 4'b0001 << g : 4'b0000;
        nk = next_k(ctx[g], in_bit[g]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) ctx[c] <= 3'd0;
            p <= 2'd0;
            hit <= 4'b0000;
            hit_total <= 16'd0;
        end else begin
            for (int c = 0; c < 4; c++)
                if (clr[c]) ctx[c] <= 3'd0;
                else if (gv && g == 2'(c)) ctx[c] <= nk;
            p <= gv ? g + 2'd1 : p;
            hit <= (gv && nk == 3'd7) ? in_ready : 4'b0000;
            if (gv && nk == 3'd7 && hit_total != 16'hFFFF) hit_total <= hit_total + 16'd1;
        end
    end
endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: scoreboard bench; a bit-history model predicts grants, hits and the hit count.
module tb_seq_det_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = 4'b0, in_bit = 4'b0, clr = 4'b0;
    logic [3:0]  in_ready, hit;
    logic [15:0] hit_total;

    seq_det_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .clr(clr), .hit(hit), .hit_total(hit_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  hit;
        logic [15:0] total;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int n_chk = 0, n_pass = 0;
    logic [6:0]  m_hist [4];
    int          m_cnt [4];
    logic [1:0]  m_p;
    logic [15:0] m_total;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [3:0] m_grant(input logic [3:0] v, input logic [3:0] c);
        int ch;
        for (int i = 0; i < 4; i++) begin
            ch = (int'(m_p) + i) % 4;
            if (v[ch] && !c[ch]) return 4'b0001 << ch;
        end
        return 4'b0000;
    endfunction

    task automatic step(input logic r, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        logic [3:0] gnt;
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; in_bit = b; clr = c;
        #1;
        gnt = r ? 4'b0000 : m_grant(v, c);
        check("in_ready", in_ready, gnt);
        e.hit = 4'b0000;
        if (r) begin
            for (int ch = 0; ch < 4; ch++) begin m_hist[ch] = 7'd0; m_cnt[ch] = 0; end
            m_p = 2'd0;
            m_total = 16'd0;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (c[ch]) begin m_hist[ch] = 7'd0; m_cnt[ch] = 0; end
                if (gnt[ch]) begin
                    m_hist[ch] = {m_hist[ch][5:0], b[ch]};
                    m_cnt[ch] = (m_cnt[ch] < 7) ? m_cnt[ch] + 1 : 7;
                    if (m_cnt[ch] == 7 && m_hist[ch] == 7'b1100111) begin
                        e.hit = gnt;
                        if (m_total != 16'hFFFF) m_total++;
`ifndef SEQ_DET_SCHED_OVERLAP_EN
                        m_cnt[ch] = 0;
`endif
                    end
                    m_p = 2'(ch + 1);
                end
            end
        end
        e.total = m_total;
        exp_q.push_back(e);
    endtask

    task automatic feed(input int ch, input string s);
        for (int i = 0; i < s.len(); i++)
            step(1'b0, 4'b0001 << ch, (s.getc(i) == "1") ? 4'b0001 << ch : 4'b0000, 4'b0000);
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, 4'b0000, 4'b0000);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("hit", hit, mon_e.hit);
            check("hit_total", hit_total, mon_e.total);
        end
    end

    initial begin
        logic [3:0] seq026 [5];
        seq026 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        step(1'b1, 4'hF, 4'hF, 4'hF);
        step(1'b1, 4'hF, 4'hF, 4'h0);
        idle();
        check("reset_hit", hit, 4'b0000);
        check("reset_total", hit_total, 16'd0);

        feed(0, "1100111");
        idle();
        check("r025_total", hit_total, 16'd1);

        step(1'b1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'hF, 4'h0, 4'h0);
            check("r026_seq", in_ready, seq026[i]);
        end

        step(1'b1, 4'h0, 4'h0, 4'h0);
        feed(2, "110011100111");
        idle();
`ifdef SEQ_DET_SCHED_OVERLAP_EN
        check("r027_total", hit_total, 16'd2);
`else
        check("r027_total", hit_total, 16'd1);
`endif

        step(1'b1, 4'h0, 4'h0, 4'h0);
        feed(1, "11001");
        step(1'b0, 4'b0010, 4'b0010, 4'b0010);
        check("r028_blocked", in_ready, 4'b0000);
        feed(1, "11");
        idle();
        check("r028_no_early_hit", hit_total, 16'd0);
        feed(1, "1100111");
        idle();
        check("r028_total", hit_total, 16'd1);

        step(1'b1, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 600; i++)
            step(1'b0, 4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);

        step(1'b1, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #2;
        force dut.hit_total = 16'hFFFE;
        #1;
        release dut.hit_total;
        m_total = 16'hFFFE;
        feed(0, "1100111");
        feed(0, "1100111");
        idle();
        check("r029_sat", hit_total, 16'hFFFF);
        feed(0, "1100111");
        idle();
        check("r029_hold", hit_total, 16'hFFFF);

        step(1'b1, 4'h0, 4'h0, 4'h0);
        feed(3, "110011");
        step(1'b1, 4'b1000, 4'b1000, 4'h0);
        feed(3, "1");
        idle();
        check("r030_hit", hit, 4'b0000);
        check("r030_total", hit_total, 16'd0);

        @(posedge clk);
        #2;
        check("queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
